// File: rtl/ber_pkg.sv
// Shared definitions for the BER checker: FSM encoding, default sizing and
// the widths derived from that default sizing.
package ber_pkg;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam int DEF_MAX_DELAY   = 32;
  localparam int DEF_SYNC_WINDOW = 511;
  localparam int DEF_COUNT_NBITS = 64;

  localparam int DELAY_NBITS = $clog2(DEF_MAX_DELAY);
  localparam int WIN_NBITS   = $clog2(DEF_SYNC_WINDOW + 1);

endpackage

// File: rtl/ber_checker_if.sv
// Symbol-side inputs and readout outputs of the BER checker.
interface ber_checker_if #(
  parameter int MAX_DELAY   = 32,
  parameter int COUNT_NBITS = 64
);
  localparam int D_NBITS = $clog2(MAX_DELAY);

  logic                   sym_valid;
  logic                   rx_bit;
  logic                   ref_bit;
  logic                   clear;
  logic                   locked;
  logic [D_NBITS-1:0]     delay_out;
  logic [COUNT_NBITS-1:0] bit_count;
  logic [COUNT_NBITS-1:0] err_count;

  // Driver side: slicer/PRBS source and host control.
  modport master (
    output sym_valid, rx_bit, ref_bit, clear,
    input  locked, delay_out, bit_count, err_count
  );

  // Checker side.
  modport slave (
    input  sym_valid, rx_bit, ref_bit, clear,
    output locked, delay_out, bit_count, err_count
  );
endinterface

// File: rtl/ber_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int NBITS = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  output logic [NBITS-1:0] value,
  output logic             full
);

  assign full = &value;

  // Count on enable, hold once full, clear has priority over counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (en && !full) begin
      value <= value + NBITS'(1);
    end
  end

endmodule

// File: rtl/ber_checker.sv
// BER checker: fills a reference history, searches MAX_DELAY alignments over
// one SYNC_WINDOW each, locks to the one with fewest errors, then counts
// compared bits and mismatches at that alignment.
module ber_checker
  import ber_pkg::*;
#(
  parameter int MAX_DELAY   = DEF_MAX_DELAY,
  parameter int SYNC_WINDOW = DEF_SYNC_WINDOW,
  parameter int COUNT_NBITS = DEF_COUNT_NBITS
) (
  input  logic          clk,
  input  logic          rst,
  ber_checker_if.slave  bus
);

  localparam int D_NBITS = $clog2(MAX_DELAY);
  localparam int W_NBITS = $clog2(SYNC_WINDOW + 1);

  localparam logic [D_NBITS-1:0] FILL_LAST = D_NBITS'(MAX_DELAY - 2);
  localparam logic [D_NBITS-1:0] CAND_LAST = D_NBITS'(MAX_DELAY - 1);
  localparam logic [W_NBITS-1:0] WIN_LAST  = W_NBITS'(SYNC_WINDOW - 1);

  state_t               state;
  logic [MAX_DELAY-2:0] hist;      // hist[i] is tap(i+1)
  logic [D_NBITS-1:0]   fill_cnt;
  logic [D_NBITS-1:0]   cand;
  logic [W_NBITS-1:0]   win;
  logic [W_NBITS-1:0]   cand_err;
  logic [W_NBITS-1:0]   best_err;
  logic [D_NBITS-1:0]   best;
  logic [D_NBITS-1:0]   delay_r;
  logic                 locked_r;

  logic [MAX_DELAY-1:0] taps;
  logic [D_NBITS-1:0]   sel;
  logic                 mm;
  logic [W_NBITS-1:0]   final_err;

  logic                   bit_en;
  logic                   err_en;
  logic                   bit_full;
  logic                   err_full;
  logic [COUNT_NBITS-1:0] bit_value;
  logic [COUNT_NBITS-1:0] err_value;

  // tap(0) is the live ref_bit; older taps come from the history register.
  assign taps = {hist, bus.ref_bit};

  // Pick the alignment under test and form this strobe's mismatch.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sel       = cand;
    if (state == ST_LOCKED) sel = delay_r;
    mm        = bus.rx_bit ^ taps[sel];
    final_err = cand_err + W_NBITS'(mm);
  end

  // Alignment FSM: FILL the history, SEARCH all candidates, then LOCKED.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    if (!rst) begin
      state    <= ST_FILL;
      // NOTE: the history is a handful of flops, not a RAM, so it is reset like any other state.
      hist     <= '0;
      fill_cnt <= '0;
      cand     <= '0;
      win      <= '0;
      cand_err <= '0;
      best_err <= '1;
      best     <= '0;
      delay_r  <= '0;
      locked_r <= 1'b0;
    end else if (bus.clear) begin
      state    <= ST_FILL;
      hist     <= '0;
      fill_cnt <= '0;
      cand     <= '0;
      win      <= '0;
      cand_err <= '0;
      best_err <= '1;
      best     <= '0;
      delay_r  <= '0;
      locked_r <= 1'b0;
    end else if (bus.sym_valid) begin
      hist <= taps[MAX_DELAY-2:0];
      case (state)
        ST_FILL: begin
          if (fill_cnt == FILL_LAST) begin
            state    <= ST_SEARCH;
            fill_cnt <= '0;
            cand     <= '0;
            win      <= '0;
            cand_err <= '0;
            best_err <= '1;
            best     <= '0;
          end else begin
            fill_cnt <= fill_cnt + D_NBITS'(1);
          end
        end
        ST_SEARCH: begin
          if (win == WIN_LAST) begin
            // Strict compare: on a tie the earlier (lower) delay is kept.
            if (final_err < best_err) begin
              best_err <= final_err;
              best     <= cand;
            end
            cand     <= cand + D_NBITS'(1);
            win      <= '0;
            cand_err <= '0;
            if (cand == CAND_LAST) begin
              state    <= ST_LOCKED;
              locked_r <= 1'b1;
              delay_r  <= (final_err < best_err) ? cand : best;
            end
          end else begin
            cand_err <= final_err;
            win      <= win + W_NBITS'(1);
          end
        end
        ST_LOCKED: begin
          // Alignment is held until clear or reset; counting happens below.
        end
        default: begin
          state <= ST_FILL;
        end
      endcase
    end
  end

  // Both counters stop together when bit_count saturates, keeping the ratio valid.
  assign bit_en = locked_r & bus.sym_valid & ~bit_full;
  assign err_en = bit_en & mm & ~err_full;

  sat_counter #(.NBITS(COUNT_NBITS)) u_bit_count (
    .clk   (clk),
    .rst   (rst),
    .clear (bus.clear),
    .en    (bit_en),
    .value (bit_value),
    .full  (bit_full)
  );

  sat_counter #(.NBITS(COUNT_NBITS)) u_err_count (
    .clk   (clk),
    .rst   (rst),
    .clear (bus.clear),
    .en    (err_en),
    .value (err_value),
    .full  (err_full)
  );

  assign bus.locked    = locked_r;
  assign bus.delay_out = delay_r;
  assign bus.bit_count = bit_value;
  assign bus.err_count = err_value;

endmodule

// File: tb/tb_ber_checker.sv
// Bench for ber_checker: a full-size instance driven with PRBS9 (lock time,
// delay selection, error counting, clear, async reset) and a small instance
// driven from a vector table (tie break, saturation).
module tb_ber_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  ber_checker_if #(.MAX_DELAY(32), .COUNT_NBITS(64)) a_if ();
  ber_checker_if #(.MAX_DELAY(4),  .COUNT_NBITS(8))  b_if ();

  ber_checker #(.MAX_DELAY(32), .SYNC_WINDOW(511), .COUNT_NBITS(64)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (a_if.slave)
  );

  ber_checker #(.MAX_DELAY(4), .SYNC_WINDOW(7), .COUNT_NBITS(8)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (b_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- full-size instance stimulus ----------------
  logic [8:0]  lfsr  = 9'h1FF;
  logic [31:0] dline = '0;
  int          dly   = 5;

  // One strobe: PRBS9 (x^9+x^5+1) reference, rx = reference delayed by dly.
  task automatic strobe_a(input int gap, input bit flip, input bit clr);
    logic r;
    r     = lfsr[8];
    lfsr  = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
    dline = {dline[30:0], r};
    @(negedge clk);
    a_if.ref_bit   = r;
    a_if.rx_bit    = dline[dly] ^ flip;
    a_if.clear     = clr;
    a_if.sym_valid = 1'b1;
    if (gap > 1) begin
      @(negedge clk);
      a_if.sym_valid = 1'b0;
      repeat (gap - 2) @(negedge clk);
    end
  endtask

  task automatic idle_a();
    @(negedge clk);
    a_if.sym_valid = 1'b0;
    a_if.clear     = 1'b0;
  endtask

  // ---------------- small instance stimulus ----------------
  task automatic strobe_b(input bit rx, input bit rf);
    @(negedge clk);
    b_if.rx_bit    = rx;
    b_if.ref_bit   = rf;
    b_if.sym_valid = 1'b1;
  endtask

  typedef struct {
    string      name;
    bit         do_clear;
    int         n;
    bit         rx;
    bit         rf;
    bit         e_locked;
    logic [1:0] e_delay;
    logic [7:0] e_bits;
    logic [7:0] e_errs;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"tie_fill",  1'b1, 30,  1'b0, 1'b0, 1'b0, 2'd0, 8'd0,   8'd0};
    vecs[1] = '{"tie_lock",  1'b0, 1,   1'b0, 1'b0, 1'b1, 2'd0, 8'd0,   8'd0};
    vecs[2] = '{"tie_count", 1'b0, 10,  1'b0, 1'b0, 1'b1, 2'd0, 8'd10,  8'd0};
    vecs[3] = '{"sat_fill",  1'b1, 30,  1'b1, 1'b0, 1'b0, 2'd0, 8'd0,   8'd0};
    vecs[4] = '{"sat_lock",  1'b0, 1,   1'b1, 1'b0, 1'b1, 2'd0, 8'd0,   8'd0};
    vecs[5] = '{"sat_mid",   1'b0, 100, 1'b1, 1'b0, 1'b1, 2'd0, 8'd100, 8'd100};
    vecs[6] = '{"sat_full",  1'b0, 200, 1'b1, 1'b0, 1'b1, 2'd0, 8'd255, 8'd255};
    vecs[7] = '{"sat_hold",  1'b0, 50,  1'b1, 1'b0, 1'b1, 2'd0, 8'd255, 8'd255};

    a_if.sym_valid = 1'b0; a_if.clear = 1'b0; a_if.rx_bit = 1'b0; a_if.ref_bit = 1'b0;
    b_if.sym_valid = 1'b0; b_if.clear = 1'b0; b_if.rx_bit = 1'b0; b_if.ref_bit = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    #3;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #20;
    check("a_rst_locked", a_if.locked, 0);
    check("a_rst_delay",  a_if.delay_out, 0);
    check("a_rst_bits",   a_if.bit_count, 0);
    check("a_rst_errs",   a_if.err_count, 0);
    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;

    // ---- small instance: table of tie-break and saturation steps ----
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].do_clear) begin
        @(negedge clk);
        b_if.sym_valid = 1'b0;
        b_if.clear     = 1'b1;
        @(negedge clk);
        b_if.clear     = 1'b0;
      end
      for (int k = 0; k < vecs[v].n; k++) strobe_b(vecs[v].rx, vecs[v].rf);
      @(negedge clk);
      b_if.sym_valid = 1'b0;
      check({vecs[v].name, "_locked"}, b_if.locked,    vecs[v].e_locked);
      check({vecs[v].name, "_delay"},  b_if.delay_out, vecs[v].e_delay);
      check({vecs[v].name, "_bits"},   b_if.bit_count, vecs[v].e_bits);
      check({vecs[v].name, "_errs"},   b_if.err_count, vecs[v].e_errs);
    end

    // ---- full instance: aligned, error-free, delay 5 ----
    dly = 5;
    for (int k = 0; k < 16382; k++) strobe_a(1, 1'b0, 1'b0);
    idle_a();
    check("a_prelock_locked", a_if.locked, 0);
    check("a_prelock_delay",  a_if.delay_out, 0);
    strobe_a(1, 1'b0, 1'b0);
    idle_a();
    check("a_lock_locked", a_if.locked, 1);
    check("a_lock_delay",  a_if.delay_out, 5);
    check("a_lock_bits",   a_if.bit_count, 0);

    for (int k = 0; k < 1000; k++) strobe_a(4, 1'b0, 1'b0);
    idle_a();
    check("a_clean_bits", a_if.bit_count, 1000);
    check("a_clean_errs", a_if.err_count, 0);

    // ---- error injection: every 100th rx bit flipped ----
    for (int k = 0; k < 1000; k++) strobe_a(4, (k % 100) == 99, 1'b0);
    idle_a();
    check("a_inject_bits", a_if.bit_count, 2000);
    check("a_inject_errs", a_if.err_count, 10);
    check("a_inject_delay", a_if.delay_out, 5);

    // ---- no strobe: everything holds ----
    repeat (5) @(negedge clk);
    check("a_hold_bits", a_if.bit_count, 2000);
    check("a_hold_errs", a_if.err_count, 10);

    // ---- async reset between clock edges ----
    @(posedge clk);
    #2;
    rst_a = 1'b0;
    #1;
    check("a_async_locked", a_if.locked, 0);
    check("a_async_delay",  a_if.delay_out, 0);
    check("a_async_bits",   a_if.bit_count, 0);
    check("a_async_errs",   a_if.err_count, 0);
    @(negedge clk);
    rst_a = 1'b1;

    // ---- clear mid-SEARCH together with a strobe, then relock at delay 3 ----
    dly = 3;
    for (int k = 0; k < 3000; k++) strobe_a(1, 1'b0, 1'b0);
    idle_a();
    check("a_search_locked", a_if.locked, 0);
    strobe_a(1, 1'b0, 1'b1);
    idle_a();
    check("a_clear_locked", a_if.locked, 0);
    check("a_clear_bits",   a_if.bit_count, 0);
    check("a_clear_errs",   a_if.err_count, 0);
    for (int k = 0; k < 16382; k++) strobe_a(1, 1'b0, 1'b0);
    idle_a();
    check("a_reprelock_locked", a_if.locked, 0);
    strobe_a(1, 1'b0, 1'b0);
    idle_a();
    check("a_relock_locked", a_if.locked, 1);
    check("a_relock_delay",  a_if.delay_out, 3);
    for (int k = 0; k < 50; k++) strobe_a(1, 1'b0, 1'b0);
    idle_a();
    check("a_relock_bits", a_if.bit_count, 50);
    check("a_relock_errs", a_if.err_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
